// File: rtl/lane_stage_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lane_stage_buffer                                            |
// | Description : Multi-lane pipeline stage register with valid/ready          |
// |               handshake, per-lane squash and whole-stage flush. SKID=1     |
// |               gives a two-entry skid buffer with a registered upstream     |
// |               ready; SKID=0 gives a single register with combinational     |
// |               ready.                                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lane_stage_buffer #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int SKID   = 1
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush_i,
  input  logic [LANES-1:0]        squash_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*DATA_W-1:0] in_data_i,
  input  logic [LANES-1:0]        in_lane_vld_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*DATA_W-1:0] out_data_o,
  output logic [LANES-1:0]        out_lane_vld_o,
  output logic [1:0]              count_o
);

  localparam int C_BW = LANES * DATA_W;

  // State code equals the number of bundles held; SKID=0 uses EMPTY/ONE only,
  // where ONE plays the role of FULL.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [C_BW-1:0]  r_main_data;
  logic [C_BW-1:0]  r_skid_data;
  logic [C_BW-1:0]  w_main_data_nxt;
  logic [C_BW-1:0]  w_skid_data_nxt;
  logic [LANES-1:0] r_main_vld;
  logic [LANES-1:0] r_skid_vld;
  logic [LANES-1:0] w_main_vld_nxt;
  logic [LANES-1:0] w_skid_vld_nxt;
  logic [C_BW-1:0]  w_in_data;
  logic [LANES-1:0] w_in_vld;
  logic             w_accept;
  logic             w_pop;
  logic             w_store;
  logic             w_clear;

  // Lane k lives in mask bit LANES-1-k and data bits [(LANES-k)*DATA_W-1 -: DATA_W],
  // so mask bit j always pairs with data slice [j*DATA_W +: DATA_W].
  assign w_in_vld = in_lane_vld_i & ~squash_i;

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign w_in_data[j*DATA_W +: DATA_W] =
        squash_i[j] ? {DATA_W{1'b0}} : in_data_i[j*DATA_W +: DATA_W];
    end
  endgenerate

  assign out_valid_o    = (r_state != S_EMPTY);
  assign out_data_o     = r_main_data;
  assign out_lane_vld_o = r_main_vld;
  assign count_o        = r_state;

  assign w_accept = in_valid_i && in_ready_o;
  assign w_pop    = out_valid_o && out_ready_i;
  // A fully squashed bundle is consumed upstream but never occupies a slot.
  assign w_store  = w_accept && (|w_in_vld);
  assign w_clear  = reset_i || flush_i;

  // Next-state and next-contents selection; out_* always show the main slot.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_vld_nxt  = r_main_vld;
    w_skid_data_nxt = r_skid_data;
    w_skid_vld_nxt  = r_skid_vld;
    if (SKID != 0) begin
      case (r_state)
        S_EMPTY: begin
          if (w_store) begin
            w_state_nxt     = S_ONE;
            w_main_data_nxt = w_in_data;
            w_main_vld_nxt  = w_in_vld;
          end
        end
        S_ONE: begin
          if (w_store && w_pop) begin
            w_main_data_nxt = w_in_data;
            w_main_vld_nxt  = w_in_vld;
          end else if (w_store) begin
            w_state_nxt     = S_TWO;
            w_skid_data_nxt = w_in_data;
            w_skid_vld_nxt  = w_in_vld;
          end else if (w_pop) begin
            w_state_nxt     = S_EMPTY;
            w_main_data_nxt = '0;
            w_main_vld_nxt  = '0;
          end
        end
        S_TWO: begin
          // Upstream ready is low here, so only a pop can happen.
          if (w_pop) begin
            w_state_nxt     = S_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_vld_nxt  = r_skid_vld;
            w_skid_data_nxt = '0;
            w_skid_vld_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt     = S_EMPTY;
          w_main_data_nxt = '0;
          w_main_vld_nxt  = '0;
          w_skid_data_nxt = '0;
          w_skid_vld_nxt  = '0;
        end
      endcase
    end else begin
      // Single register: pop plus accept simply overwrites, giving no bubble.
      if (w_store) begin
        w_state_nxt     = S_ONE;
        w_main_data_nxt = w_in_data;
        w_main_vld_nxt  = w_in_vld;
      end else if (w_pop) begin
        w_state_nxt     = S_EMPTY;
        w_main_data_nxt = '0;
        w_main_vld_nxt  = '0;
      end
    end
  end

  // State and payload registers; flush and reset both empty and zero the stage.
  always_ff @(posedge clock_i) begin
    if (w_clear) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_vld  <= '0;
      r_skid_data <= '0;
      r_skid_vld  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_vld  <= w_main_vld_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_vld  <= w_skid_vld_nxt;
    end
  end

  generate
    if (SKID != 0) begin : g_skid_ready
      logic r_in_ready;
      // Registered ready: low exactly while both slots are occupied.
      always_ff @(posedge clock_i) begin
        if (w_clear) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != S_TWO);
        end
      end
      assign in_ready_o = r_in_ready;
    end else begin : g_comb_ready
      assign in_ready_o = !out_valid_o || out_ready_i;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lane_stage_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lane_stage_buffer                                         |
// | Description : Bench for lane_stage_buffer. Drives one stimulus stream into |
// |               a SKID=1 and a SKID=0 instance and compares both against     |
// |               queue-based reference models.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lane_stage_buffer;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  squash;
  logic [1:0]  lane_vld;
  logic [63:0] in_data;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [1:0]  s_out_vld, s_count;
  logic        f_in_ready, f_out_valid;
  logic [63:0] f_out_data;
  logic [1:0]  f_out_vld, f_count;

  always #5 clk = ~clk;

  lane_stage_buffer #(.LANES(LANES), .DATA_W(DATA_W), .SKID(1)) u_skid (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .squash_i(squash),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_data_i(in_data),
    .in_lane_vld_i(lane_vld), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
    .out_data_o(s_out_data), .out_lane_vld_o(s_out_vld), .count_o(s_count)
  );

  lane_stage_buffer #(.LANES(LANES), .DATA_W(DATA_W), .SKID(0)) u_flat (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .squash_i(squash),
    .in_valid_i(in_valid), .in_ready_o(f_in_ready), .in_data_i(in_data),
    .in_lane_vld_i(lane_vld), .out_valid_o(f_out_valid), .out_ready_i(out_ready),
    .out_data_o(f_out_data), .out_lane_vld_o(f_out_vld), .count_o(f_count)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  v;
  } bundle_t;

  bundle_t qs[$];      // bundles held by the SKID=1 stage, head = presented
  bundle_t qf[$];      // bundles held by the SKID=0 stage
  bit      rdy_s;      // registered upstream ready of the SKID=1 stage
  bit      cleared;    // previous edge saw reset or flush
  int      n_checks = 0;
  int      n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bundle as it must be stored: squashed lanes invalid and zeroed.
  function automatic bundle_t mk(input logic [63:0] d, input logic [1:0] v, input logic [1:0] sq);
    bundle_t b;
    b.v = v & ~sq;
    b.d = d;
    for (int j = 0; j < 2; j++) if (sq[j]) b.d[j*32 +: 32] = 32'h0;
    return b;
  endfunction

  // One clock: check both DUTs at the falling edge, then advance the models.
  task automatic tick();
    bit      acc_s, pop_s, acc_f, pop_f, rdy_f;
    bundle_t nb;
    @(negedge clk);
    rdy_f = (qf.size() == 0) || out_ready;
    chk("skid.in_ready",  s_in_ready,  rdy_s);
    chk("skid.out_valid", s_out_valid, qs.size() != 0);
    chk("skid.count",     s_count,     qs.size());
    if (qs.size() != 0) begin
      chk("skid.out_data", s_out_data, qs[0].d);
      chk("skid.lane_vld", s_out_vld,  qs[0].v);
    end
    chk("flat.in_ready",  f_in_ready,  rdy_f);
    chk("flat.out_valid", f_out_valid, qf.size() != 0);
    chk("flat.count",     f_count,     qf.size());
    if (qf.size() != 0) begin
      chk("flat.out_data", f_out_data, qf[0].d);
      chk("flat.lane_vld", f_out_vld,  qf[0].v);
    end
    if (cleared) begin
      chk("skid.clear_data", s_out_data, 64'h0);
      chk("skid.clear_vld",  s_out_vld,  64'h0);
      chk("flat.clear_data", f_out_data, 64'h0);
      chk("flat.clear_vld",  f_out_vld,  64'h0);
    end
    nb    = mk(in_data, lane_vld, squash);
    acc_s = in_valid && rdy_s;
    pop_s = (qs.size() != 0) && out_ready;
    acc_f = in_valid && rdy_f;
    pop_f = (qf.size() != 0) && out_ready;
    cleared = rst || flush;
    @(posedge clk);
    if (rst || flush) begin
      qs.delete();
      qf.delete();
      rdy_s = 1'b1;
    end else begin
      if (pop_s) void'(qs.pop_front());
      if (acc_s && nb.v != 2'b00) qs.push_back(nb);
      rdy_s = (qs.size() != 2);
      if (pop_f) void'(qf.pop_front());
      if (acc_f && nb.v != 2'b00) qf.push_back(nb);
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [63:0] d, input logic [1:0] lv,
                       input logic [1:0] sq, input bit ordy);
    in_valid  = v;
    in_data   = d;
    lane_vld  = lv;
    squash    = sq;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(0, 64'h0, 2'b00, 2'b00, 1);
    rdy_s = 1'b1;
    cleared = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();                       // reset state, reset still held
    rst = 1'b0;

    // Pass-through, one bundle per cycle
    drive(1, 64'h00000013_00100093, 2'b11, 2'b00, 1); tick();
    drive(1, 64'h00200113_00300193, 2'b11, 2'b00, 1); tick();
    drive(0, 64'h0, 2'b00, 2'b00, 1); tick(); tick();

    // Backpressure: A, B accepted, C waits for space
    drive(1, 64'hAAAA0001_AAAA0002, 2'b11, 2'b00, 0); tick();
    drive(1, 64'hBBBB0001_BBBB0002, 2'b11, 2'b00, 0); tick();
    drive(1, 64'hCCCC0001_CCCC0002, 2'b11, 2'b00, 0); tick(); tick();
    chk("skid.bp_count", s_count, 64'd2);
    drive(1, 64'hCCCC0001_CCCC0002, 2'b11, 2'b00, 1); tick();
    drive(0, 64'h0, 2'b00, 2'b00, 1); tick(); tick(); tick(); tick();

    // Squash one lane, then both
    drive(1, 64'h11111111_22222222, 2'b11, 2'b01, 1); tick();
    chk("skid.squash_vld", s_out_vld, 64'h2);
    chk("skid.squash_data", s_out_data, 64'h11111111_00000000);
    drive(1, 64'h33333333_44444444, 2'b11, 2'b11, 1); tick();
    drive(0, 64'h0, 2'b00, 2'b00, 1); tick(); tick();

    // Flush with both slots occupied and a bundle offered
    drive(1, 64'h55550001_55550002, 2'b11, 2'b00, 0); tick();
    drive(1, 64'h66660001_66660002, 2'b11, 2'b00, 0); tick();
    flush = 1'b1;
    drive(1, 64'h77770001_77770002, 2'b11, 2'b00, 1); tick();
    flush = 1'b0;
    drive(0, 64'h0, 2'b00, 2'b00, 1); tick(); tick();

    // Reset while one bundle is held, then 1-cycle latency afterwards
    drive(1, 64'h88880001_88880002, 2'b10, 2'b00, 0); tick();
    drive(0, 64'h0, 2'b00, 2'b00, 0); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    drive(1, 64'h99990001_99990002, 2'b11, 2'b00, 1); tick();
    drive(0, 64'h0, 2'b00, 2'b00, 1); tick(); tick();

    // Back-to-back with out_ready toggling 1,0,1
    drive(1, 64'hD0000001_D0000002, 2'b11, 2'b00, 1); tick();
    drive(1, 64'hD1000001_D1000002, 2'b11, 2'b00, 0); tick();
    drive(1, 64'hD2000001_D2000002, 2'b11, 2'b00, 1); tick();
    drive(1, 64'hD3000001_D3000002, 2'b01, 2'b00, 1); tick();
    drive(0, 64'h0, 2'b00, 2'b00, 1); tick(); tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, {$urandom, $urandom}, 2'($urandom),
            (($urandom % 4) == 0) ? 2'($urandom) : 2'b00, ($urandom % 3) != 0);
      flush = (($urandom % 40) == 0);
      rst   = (($urandom % 97) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    drive(0, 64'h0, 2'b00, 2'b00, 1); tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
